hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/hazard_forward.sv | 23 ++
 rtl/hazard_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: result-source codes, forwarding selects and
// the hazard-unit FSM state type.
package pipeline_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_forward.sv
// Forwarding select for one execute-stage operand; the memory stage is newer
// than writeback and therefore wins when both match.
module hazard_forward
    import pipeline_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] Forward
);

    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
            Forward = FWD_M;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
            Forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stalls, branch flushes and
// data-memory wait handling with timeout. Define HAZARD_PERF_EN to add the
// StallCount/FlushCount performance counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [DATA_WIDTH-1:0] StallCount,
    output logic [DATA_WIDTH-1:0] FlushCount
`endif
);

    localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    hazard_state_t state;
    hazard_state_t state_next;
    logic [7:0]    wait_cnt;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          lw_stall;
    logic          mem_hold;
    logic          timeout_exit;

    hazard_forward u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (fwd_a)
    );

    hazard_forward u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (fwd_b)
    );

    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    assign lw_stall = (ResultSrcE == RESULT_MEM) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    assign mem_hold = ((state == RUN) && MemReqM && !MemReadyM) || (state == MEM_WAIT);

    // The counter reaches the limit on the edge that ends this MEM_WAIT cycle,
    // so the exit decision looks one count ahead.
    assign timeout_exit = (state == MEM_WAIT) && !MemReadyM && (wait_cnt >= WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM || timeout_exit) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            FlushD = PCSrcE;
            FlushE = PCSrcE | lw_stall;
            StallF = lw_stall & ~PCSrcE;
            StallD = lw_stall & ~PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= 8'd0;
            MemTimeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == RUN) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_exit) begin
                MemTimeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            StallCount <= StallCount + DATA_WIDTH'(StallF);
            FlushCount <= FlushCount + DATA_WIDTH'(FlushE);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second instance with
// TIMEOUT_CYCLES=3 covers the memory timeout path.
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemReqM, MemReadyM;

    logic [1:0] ForwardAE, ForwardBE, ForwardAE_t, ForwardBE_t;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic       StallF_t, StallD_t, StallE_t, StallM_t, FlushD_t, FlushE_t, FlushW_t, MemTimeout_t;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCount, FlushCount, StallCount_t, FlushCount_t;
`endif

    // Control outputs packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    logic [6:0] ctl, ctl_t;
    assign ctl   = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    assign ctl_t = {StallF_t, StallD_t, StallE_t, StallM_t, FlushD_t, FlushE_t, FlushW_t};

    int total = 0;
    int bad   = 0;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    hazard_unit #(.TIMEOUT_CYCLES(3)) dut_t (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE_t), .ForwardBE(ForwardBE_t),
        .StallF(StallF_t), .StallD(StallD_t), .StallE(StallE_t), .StallM(StallM_t),
        .FlushD(FlushD_t), .FlushE(FlushE_t), .FlushW(FlushW_t), .MemTimeout(MemTimeout_t)
`ifdef HAZARD_PERF_EN
        , .StallCount(StallCount_t), .FlushCount(FlushCount_t)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        Rs2E = 5'd6; RdW = 5'd6; RegWriteW = 1'b1;
        MemReqM = 1'b1; PCSrcE = 1'b1;
        #2;
        total++;
        if (ctl !== 7'b0000111) begin
            bad++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl, 7'b0000111);
        end
        total++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_fwd: got %b want %b", {ForwardAE, ForwardBE}, 4'b0000);
        end
        tick();
        tick();
        clear_inputs();
        rst = 1'b0;
        #2;
        total++;
        if (ctl !== 7'b0000000 || MemTimeout !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset: got ctl=%b to=%b want 0000000 0", ctl, MemTimeout);
        end
`ifdef HAZARD_PERF_EN
        total++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", StallCount, FlushCount);
        end
`endif
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        Rs2E = 5'd9;
        #2;
        total++;
        if (ForwardAE !== 2'b10) begin
            bad++; $display("[TB] FAIL fwd_m_priority: got %b want %b", ForwardAE, 2'b10);
        end
        total++;
        if (ForwardBE !== 2'b00) begin
            bad++; $display("[TB] FAIL fwd_b_nomatch: got %b want %b", ForwardBE, 2'b00);
        end
        RegWriteM = 1'b0;
        #2;
        total++;
        if (ForwardAE !== 2'b01) begin
            bad++; $display("[TB] FAIL fwd_w: got %b want %b", ForwardAE, 2'b01);
        end
        RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #2;
        total++;
        if (ForwardAE !== 2'b00) begin
            bad++; $display("[TB] FAIL fwd_x0: got %b want %b", ForwardAE, 2'b00);
        end
        Rs2E = 5'd9; RdW = 5'd9; RdM = 5'd4;
        #2;
        total++;
        if (ForwardBE !== 2'b01) begin
            bad++; $display("[TB] FAIL fwd_b_w: got %b want %b", ForwardBE, 2'b01);
        end
        RdM = 5'd9;
        #2;
        total++;
        if (ForwardBE !== 2'b10 || ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL fwd_b_m: got %b ctl=%b want 10 0000000", ForwardBE, ctl);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b0;
        #2;
        total++;
        if (ctl !== 7'b1100010) begin
            bad++; $display("[TB] FAIL load_use: got %b want %b", ctl, 7'b1100010);
        end
        tick();
        ResultSrcE = 2'b00;
        #2;
        total++;
        if (ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL load_use_release: got %b want %b", ctl, 7'b0000000);
        end
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #2;
        total++;
        if (ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL load_use_x0: got %b want %b", ctl, 7'b0000000);
        end
        ResultSrcE = 2'b10; RdE = 5'd7; Rs2D = 5'd7;
        #2;
        total++;
        if (ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL pc4_no_stall: got %b want %b", ctl, 7'b0000000);
        end
        tick();
    endtask

    task automatic test_branch_lw();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
        #2;
        total++;
        if (ctl !== 7'b0000110) begin
            bad++; $display("[TB] FAIL branch_over_lw: got %b want %b", ctl, 7'b0000110);
        end
        ResultSrcE = 2'b00;
        #2;
        total++;
        if (ctl !== 7'b0000110) begin
            bad++; $display("[TB] FAIL branch_only: got %b want %b", ctl, 7'b0000110);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) MemReadyM = 1'b1;
            #2;
            total++;
            if (ctl !== 7'b1111001) begin
                bad++; $display("[TB] FAIL mem_wait_c%0d: got %b want %b", c, ctl, 7'b1111001);
            end
            if (c == 3) begin
                total++;
                if (ForwardAE !== 2'b10) begin
                    bad++; $display("[TB] FAIL mem_wait_fwd: got %b want %b", ForwardAE, 2'b10);
                end
            end
            tick();
        end
        ResultSrcE = 2'b00;
        #2;
        total++;
        if (ctl !== 7'b0000110 || MemTimeout !== 1'b0) begin
            bad++; $display("[TB] FAIL mem_wait_run: got ctl=%b to=%b want 0000110 0", ctl, MemTimeout);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #2;
            total++;
            if (ctl_t !== 7'b1111001 || MemTimeout_t !== 1'b0) begin
                bad++; $display("[TB] FAIL timeout_wait_c%0d: got ctl=%b to=%b want 1111001 0", c, ctl_t, MemTimeout_t);
            end
            tick();
        end
        MemReqM = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            #2;
            total++;
            if (ctl_t !== 7'b0000000 || MemTimeout_t !== 1'b1) begin
                bad++; $display("[TB] FAIL timeout_exit_c%0d: got ctl=%b to=%b want 0000000 1", c, ctl_t, MemTimeout_t);
            end
            tick();
        end
        MemReqM = 1'b1;
        tick();
        MemReadyM = 1'b1;
        tick();
        MemReqM = 1'b0;
        #2;
        total++;
        if (ctl_t !== 7'b0000000 || MemTimeout_t !== 1'b1) begin
            bad++; $display("[TB] FAIL timeout_sticky: got ctl=%b to=%b want 0000000 1", ctl_t, MemTimeout_t);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        total++;
        if (MemTimeout_t !== 1'b0) begin
            bad++; $display("[TB] FAIL timeout_cleared: got %b want %b", MemTimeout_t, 1'b0);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        tick();
        tick();
        tick();
        // Fourth cycle would be the timeout exit of the 3-cycle instance
`ifdef HAZARD_PERF_EN
        #2;
        total++;
        if (StallCount_t !== 32'd3 || FlushCount_t !== 32'd0) begin
            bad++; $display("[TB] FAIL perf_before_reset: got %0d/%0d want 3/0", StallCount_t, FlushCount_t);
        end
`endif
        rst = 1'b1;
        #2;
        total++;
        if (ctl_t !== 7'b0000111) begin
            bad++; $display("[TB] FAIL mid_wait_rst_ctl: got %b want %b", ctl_t, 7'b0000111);
        end
        tick();
        rst = 1'b0;
        MemReqM = 1'b0;
        #2;
        total++;
        if (ctl_t !== 7'b0000000 || MemTimeout_t !== 1'b0 || ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL mid_wait_abandon: got t=%b to=%b d=%b want 0000000 0 0000000", ctl_t, MemTimeout_t, ctl);
        end
`ifdef HAZARD_PERF_EN
        total++;
        if (StallCount_t !== 32'd0 || FlushCount_t !== 32'd0) begin
            bad++; $display("[TB] FAIL mid_wait_perf: got %0d/%0d want 0/0", StallCount_t, FlushCount_t);
        end
`endif
        tick();
        #2;
        total++;
        if (MemTimeout_t !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_wait_no_flag: got %b want %b", MemTimeout_t, 1'b0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #2;
        total++;
        if (ctl !== 7'b1100010) begin
            bad++; $display("[TB] FAIL b2b_lw1: got %b want %b", ctl, 7'b1100010);
        end
        tick();
        RdE = 5'd8; Rs1D = 5'd8; Rs2D = 5'd0;
        #2;
        total++;
        if (ctl !== 7'b1100010) begin
            bad++; $display("[TB] FAIL b2b_lw2: got %b want %b", ctl, 7'b1100010);
        end
        tick();
        ResultSrcE = 2'b00; PCSrcE = 1'b1;
        #2;
        total++;
        if (ctl !== 7'b0000110) begin
            bad++; $display("[TB] FAIL b2b_branch: got %b want %b", ctl, 7'b0000110);
        end
        tick();
        PCSrcE = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b1;
        #2;
        total++;
        if (ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL b2b_mem_ready: got %b want %b", ctl, 7'b0000000);
        end
        tick();
        #2;
        total++;
        if (ctl !== 7'b0000000) begin
            bad++; $display("[TB] FAIL b2b_mem_ready2: got %b want %b", ctl, 7'b0000000);
        end
`ifdef HAZARD_PERF_EN
        total++;
        if (StallCount !== 32'd2 || FlushCount !== 32'd3) begin
            bad++; $display("[TB] FAIL b2b_perf: got %0d/%0d want 2/3", StallCount, FlushCount);
        end
`endif
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #3;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_lw();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
